// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg
// Shared definitions for the ALU, the control unit and the ALU operation
// sequencer:
//   - 5-bit ALU opcodes (OP_*), including OP_NOP, which makes the ALU output 0
//   - writeback target encodings (WB_GPR / WB_LO / WB_HI)
//   - sequencer FSM state type
//   - is_supported(): true for the opcodes the sequencer will execute
package alu_ops_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] WB_GPR = 2'd0;
  localparam logic [1:0] WB_LO  = 2'd1;
  localparam logic [1:0] WB_HI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } seq_state_t;

  function automatic logic is_supported(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_supported = 1'b1;
      default:                                       is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multicycle initiator between instruction issue and the combinational ALU.
// Accepts one request, runs it through the ALU for one cycle, captures the
// 2*DATA_W result into Z, then writes it back: one GPR beat, or LO then HI
// beats for mul/div.
//
// Ports:
//   clock, clear       rising-edge clock, asynchronous active-low reset
//   req_*              request handshake (valid/ready) with opcode, A, B, rz
//   alu_y/alu_b/alu_opcode  operands and opcode to the ALU; alu_c is its result
//   wb_*               writeback handshake (valid/ready), target, index, data
//   z_out              Z register for observation
//   illegal            one-cycle pulse after accepting an unsupported opcode
//   busy               high in every state except IDLE
module alu_op_sequencer
  import alu_ops_pkg::*;
#(
  parameter int REG_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_opcode,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  input  logic [REG_IDX_W-1:0]  req_rz,
  output logic [DATA_W-1:0]     alu_y,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            alu_opcode,
  input  logic [2*DATA_W-1:0]   alu_c,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [1:0]            wb_sel,
  output logic [REG_IDX_W-1:0]  wb_idx,
  output logic [DATA_W-1:0]     wb_data,
  output logic [2*DATA_W-1:0]   z_out,
  output logic                  illegal,
  output logic                  busy
);

  seq_state_t state, state_next;

  logic [DATA_W-1:0]    y_reg;
  logic [DATA_W-1:0]    b_reg;
  logic [4:0]           op_reg;
  logic [REG_IDX_W-1:0] rz_reg;
  logic [2*DATA_W-1:0]  z_reg;
  logic                 illegal_q;

  logic accept;
  logic two_beat;

  assign accept   = req_valid && (state == ST_IDLE);
  assign two_beat = (op_reg == OP_MUL) || (op_reg == OP_DIV);

  // Operands are latched on every accept, including unsupported opcodes;
  // the illegal pulse is registered so it lands in the cycle after accept.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      y_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_NOP;
      rz_reg    <= '0;
      z_reg     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= accept && !is_supported(req_opcode);
      if (accept) begin
        y_reg  <= req_a;
        b_reg  <= req_b;
        op_reg <= req_opcode;
        rz_reg <= req_rz;
      end
      if (state == ST_EXEC) begin
        z_reg <= alu_c;
      end
    end
  end

  // Next state and outputs. The ALU sees OP_NOP outside EXEC so its output
  // settles to 0; wb_idx is only driven for GPR beats.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    alu_opcode = OP_NOP;
    wb_valid   = 1'b0;
    wb_sel     = WB_GPR;
    wb_idx     = '0;
    wb_data    = '0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid && is_supported(req_opcode)) begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_opcode = op_reg;
        state_next = ST_WB_LO;
      end

      ST_WB_LO: begin
        wb_valid = 1'b1;
        wb_data  = z_reg[DATA_W-1:0];
        if (two_beat) begin
          wb_sel = WB_LO;
        end else begin
          wb_sel = WB_GPR;
          wb_idx = rz_reg;
        end
        if (wb_ready) begin
          state_next = two_beat ? ST_WB_HI : ST_IDLE;
        end
      end

      ST_WB_HI: begin
        wb_valid = 1'b1;
        wb_sel   = WB_HI;
        wb_data  = z_reg[2*DATA_W-1:DATA_W];
        if (wb_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign alu_y   = y_reg;
  assign alu_b   = b_reg;
  assign z_out   = z_reg;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. A behavioural ALU sits on the
// alu_* ports. Expected writeback beats are pushed to a queue when a request
// is issued and popped by a monitor on every completed beat.
module tb_alu_op_sequencer;
  import alu_ops_pkg::*;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  logic                 clock;
  logic                 clear;
  logic                 req_valid;
  logic                 req_ready;
  logic [4:0]           req_opcode;
  logic [DATA_W-1:0]    req_a;
  logic [DATA_W-1:0]    req_b;
  logic [REG_IDX_W-1:0] req_rz;
  logic [DATA_W-1:0]    alu_y;
  logic [DATA_W-1:0]    alu_b;
  logic [4:0]           alu_opcode;
  logic [2*DATA_W-1:0]  alu_c;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [1:0]           wb_sel;
  logic [REG_IDX_W-1:0] wb_idx;
  logic [DATA_W-1:0]    wb_data;
  logic [2*DATA_W-1:0]  z_out;
  logic                 illegal;
  logic                 busy;

  typedef struct packed {
    logic [1:0]           sel;
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_beat;

  int vectors_applied = 0;
  int miscompares     = 0;
  int cycle_cnt       = 0;
  int acc_first;
  int acc_second;

  alu_op_sequencer #(
    .REG_IDX_W(REG_IDX_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opcode(req_opcode),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rz    (req_rz),
    .alu_y     (alu_y),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_c     (alu_c),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_sel    (wb_sel),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .z_out     (z_out),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Behavioural ALU: mul is signed, div gives quotient low / remainder high.
  function automatic logic [63:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] y,
                                            input logic [31:0] b);
    logic [63:0] yy;
    longint      sy, sb;
    int          iy, ib;
    yy = {y, y};
    sy = longint'($signed(y));
    sb = longint'($signed(b));
    iy = $signed(y);
    ib = $signed(b);
    case (op)
      OP_ADD:  alu_model = {32'h0, y + b};
      OP_SUB:  alu_model = {32'h0, y - b};
      OP_SHR:  alu_model = {32'h0, y >> b[4:0]};
      OP_SHRA: alu_model = {32'h0, 32'($signed(y) >>> b[4:0])};
      OP_SHL:  alu_model = {32'h0, y << b[4:0]};
      OP_ROR:  alu_model = {32'h0, 32'(yy >> b[4:0])};
      OP_ROL:  alu_model = {32'h0, 32'((yy << b[4:0]) >> 32)};
      OP_AND:  alu_model = {32'h0, y & b};
      OP_OR:   alu_model = {32'h0, y | b};
      OP_MUL:  alu_model = 64'(sy * sb);
      OP_DIV:  alu_model = (b == 32'h0) ? {y, 32'hFFFF_FFFF}
                                        : {32'(iy % ib), 32'(iy / ib)};
      OP_NEG:  alu_model = {32'h0, 32'h0 - b};
      OP_NOT:  alu_model = {32'h0, ~b};
      default: alu_model = 64'h0;
    endcase
  endfunction

  always_comb alu_c = alu_model(alu_opcode, alu_y, alu_b);

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, actual, expected, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for req_ready, issues one request, records the accept
  // edge number and returns in the cycle after the accept.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [REG_IDX_W-1:0] rz,
                               output int accept_cycle);
    logic [63:0] r;
    int          n;
    n = 0;
    accept_cycle = -1;
    while (!req_ready && n < 20) begin
      waitCycle();
      n++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_rz     = rz;
    if (is_supported(op)) begin
      r = alu_model(op, a, b);
      if (op == OP_MUL || op == OP_DIV) begin
        exp_q.push_back('{sel: WB_LO, idx: '0, data: r[31:0]});
        exp_q.push_back('{sel: WB_HI, idx: '0, data: r[63:32]});
      end else begin
        exp_q.push_back('{sel: WB_GPR, idx: rz, data: r[31:0]});
      end
    end
    waitCycle();
    accept_cycle = cycle_cnt;
    req_valid = 1'b0;
  endtask

  task automatic drainScoreboard();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      waitCycle();
      n++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every completed beat must match the oldest expected beat.
  always @(negedge clock) begin
    if (clear && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_beat = exp_q.pop_front();
        checkOutput("sb_wb_sel", 64'(wb_sel), 64'(mon_beat.sel));
        if (mon_beat.sel == WB_GPR) begin
          checkOutput("sb_wb_idx", 64'(wb_idx), 64'(mon_beat.idx));
        end
        checkOutput("sb_wb_data", 64'(wb_data), 64'(mon_beat.data));
      end
    end
    if (illegal && wb_valid) begin
      checkOutput("illegal_with_wb_valid", 64'd1, 64'd0);
    end
  end

  logic [4:0] sup_ops [13] = '{OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
                               OP_ROR, OP_ROL, OP_AND, OP_OR, OP_MUL,
                               OP_DIV, OP_NEG, OP_NOT};

  initial begin
    clear      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_rz     = '0;
    wb_ready   = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);
    checkOutput("rst_z_out", z_out, 64'd0);
    checkOutput("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    checkOutput("rst_alu_y", 64'(alu_y), 64'd0);
    checkOutput("rst_wb_data", 64'(wb_data), 64'd0);
    clear = 1'b1;
    waitCycle();

    // Add: 5 + 7 -> r3, one beat at t0+2, idle at t0+3
    $display("[TB] add");
    applyStimulus(OP_ADD, 32'd5, 32'd7, 4'd3, acc_first);
    checkOutput("add_exec_busy", 64'(busy), 64'd1);
    checkOutput("add_exec_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("add_exec_req_ready", 64'(req_ready), 64'd0);
    checkOutput("add_exec_alu_opcode", 64'(alu_opcode), 64'(OP_ADD));
    checkOutput("add_exec_alu_y", 64'(alu_y), 64'd5);
    checkOutput("add_exec_alu_b", 64'(alu_b), 64'd7);
    waitCycle();
    checkOutput("add_wb_valid", 64'(wb_valid), 64'd1);
    checkOutput("add_wb_sel", 64'(wb_sel), 64'(WB_GPR));
    checkOutput("add_wb_idx", 64'(wb_idx), 64'd3);
    checkOutput("add_wb_data", 64'(wb_data), 64'd12);
    checkOutput("add_wb_alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
    waitCycle();
    checkOutput("add_idle_req_ready", 64'(req_ready), 64'd1);
    checkOutput("add_idle_wb_valid", 64'(wb_valid), 64'd0);

    // Mul: 0x10000 * 0x10000 -> LO 0, HI 1
    $display("[TB] mul");
    applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd1, acc_first);
    waitCycle();
    checkOutput("mul_lo_sel", 64'(wb_sel), 64'(WB_LO));
    checkOutput("mul_lo_data", 64'(wb_data), 64'h0);
    waitCycle();
    checkOutput("mul_hi_valid", 64'(wb_valid), 64'd1);
    checkOutput("mul_hi_sel", 64'(wb_sel), 64'(WB_HI));
    checkOutput("mul_hi_data", 64'(wb_data), 64'h1);
    checkOutput("mul_z_out", z_out, 64'h0000_0001_0000_0000);
    waitCycle();
    checkOutput("mul_idle_req_ready", 64'(req_ready), 64'd1);

    // Div 17/5 with wb_ready held low -> LO 3 stable, then HI 2
    $display("[TB] div with backpressure");
    wb_ready = 1'b0;
    applyStimulus(OP_DIV, 32'd17, 32'd5, 4'd2, acc_first);
    checkOutput("div_exec_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("div_hold_valid", 64'(wb_valid), 64'd1);
      checkOutput("div_hold_sel", 64'(wb_sel), 64'(WB_LO));
      checkOutput("div_hold_data", 64'(wb_data), 64'd3);
      checkOutput("div_hold_req_ready", 64'(req_ready), 64'd0);
    end
    waitCycle();
    checkOutput("div_hold_last_data", 64'(wb_data), 64'd3);
    wb_ready = 1'b1;
    waitCycle();
    checkOutput("div_hi_sel", 64'(wb_sel), 64'(WB_HI));
    checkOutput("div_hi_data", 64'(wb_data), 64'd2);
    checkOutput("div_hi_req_ready", 64'(req_ready), 64'd0);
    waitCycle();
    checkOutput("div_idle_req_ready", 64'(req_ready), 64'd1);

    // Illegal opcodes 00000 and 11111
    $display("[TB] illegal opcodes");
    applyStimulus(5'b00000, 32'd1, 32'd2, 4'd4, acc_first);
    checkOutput("ill0_pulse", 64'(illegal), 64'd1);
    checkOutput("ill0_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("ill0_req_ready", 64'(req_ready), 64'd1);
    waitCycle();
    checkOutput("ill0_pulse_end", 64'(illegal), 64'd0);
    applyStimulus(5'b11111, 32'd1, 32'd2, 4'd4, acc_first);
    checkOutput("ill31_pulse", 64'(illegal), 64'd1);
    checkOutput("ill31_busy", 64'(busy), 64'd0);
    waitCycle();
    checkOutput("ill31_pulse_end", 64'(illegal), 64'd0);
    checkOutput("ill31_wb_valid", 64'(wb_valid), 64'd0);

    // Reset during the HI beat of a mul
    $display("[TB] reset mid-op");
    wb_ready = 1'b1;
    applyStimulus(OP_MUL, 32'd3, 32'hFFFF_FFFE, 4'd0, acc_first);
    waitCycle();
    waitCycle();
    checkOutput("rmid_in_hi", 64'(wb_sel), 64'(WB_HI));
    clear = 1'b0;
    #1;
    checkOutput("rmid_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rmid_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rmid_busy", 64'(busy), 64'd0);
    checkOutput("rmid_z_out", z_out, 64'd0);
    checkOutput("rmid_alu_y", 64'(alu_y), 64'd0);
    checkOutput("rmid_alu_b", 64'(alu_b), 64'd0);
    checkOutput("rmid_wb_data", 64'(wb_data), 64'd0);
    exp_q.delete();
    waitCycle();
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      checkOutput("rmid_no_beat", 64'(wb_valid), 64'd0);
    end

    // Back-to-back: sub then ror, accepts exactly 3 cycles apart
    $display("[TB] back-to-back");
    applyStimulus(OP_SUB, 32'd10, 32'd3, 4'd5, acc_first);
    applyStimulus(OP_ROR, 32'd1, 32'd1, 4'd6, acc_second);
    checkOutput("b2b_accept_gap", 64'(acc_second - acc_first), 64'd3);
    drainScoreboard();

    // Every supported opcode with random operands, issued back to back
    $display("[TB] opcode sweep");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(sup_ops[i], $urandom, $urandom | 32'h1,
                    REG_IDX_W'($urandom_range(0, 15)), acc_first);
    end
    drainScoreboard();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors_applied, miscompares);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
